// File: rtl/button_event_arbiter_if.sv
// ---------------------------------------------------------------------------
// button_event_arbiter_if
// Event port between the front-panel button controller and the processor.
//   event_valid  an event code is on offer (controller -> processor)
//   event_code   channel index of the offered event, stable while valid
//   event_ack    processor has consumed the offered code (processor -> controller)
//   pending      per-channel posted-but-unacknowledged flags
//   overrun      one-cycle pulse when a press merges into a pending event
// The controller side uses the master modport, the processor the slave.
// ---------------------------------------------------------------------------
interface button_event_arbiter_if #(
    parameter int NUM_BUTTONS = 4,
    parameter int CODE_W      = 2
);
    logic                   event_valid;
    logic [CODE_W-1:0]      event_code;
    logic                   event_ack;
    logic [NUM_BUTTONS-1:0] pending;
    logic                   overrun;

    modport master (
        output event_valid,
        output event_code,
        output pending,
        output overrun,
        input  event_ack
    );

    modport slave (
        input  event_valid,
        input  event_code,
        input  pending,
        input  overrun,
        output event_ack
    );
endinterface

// File: rtl/button_event_arbiter.sv
// ---------------------------------------------------------------------------
// button_event_arbiter
// Synchronizes and debounces NUM_BUTTONS raw active-low buttons, turns each
// accepted press into a pending event, and offers pending events one at a
// time to the processor through a round-robin arbiter.
//   clock             system clock, all state changes on posedge
//   reset             synchronous active-high reset
//   buttonNotPressed  raw asynchronous buttons, 0 = pressed
//   evt               event port (valid/code/ack, pending flags, overrun)
// ---------------------------------------------------------------------------
module button_event_arbiter #(
    parameter int NUM_BUTTONS     = 4,
    parameter int CODE_W          = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttonNotPressed,
    button_event_arbiter_if.master evt
);

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_PRESS_WAIT,
        CH_HELD,
        CH_RELEASE_WAIT
    } chState_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_OFFER
    } arbState_t;

    // The counter holds (stable samples - 1), so a level change is accepted
    // when a further stable sample arrives with the counter at D-2.
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [NUM_BUTTONS-1:0] syncA_q, syncB_q;
    chState_t               chState_q [NUM_BUTTONS];
    chState_t               chState_d [NUM_BUTTONS];
    logic [CNT_W-1:0]       cnt_q     [NUM_BUTTONS];
    logic [CNT_W-1:0]       cnt_d     [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] post;

    arbState_t              arbState_q, arbState_d;
    logic                   eventValid_q, eventValid_d;
    logic [CODE_W-1:0]      eventCode_q, eventCode_d;
    logic [CODE_W-1:0]      lastGrant_q, lastGrant_d;
    logic [NUM_BUTTONS-1:0] pending_q, pending_d;
    logic                   overrun_q, overrun_d;
    logic [NUM_BUTTONS-1:0] clearMask;
    logic                   found;
    logic [CODE_W-1:0]      pickIdx;

    assign evt.event_valid = eventValid_q;
    assign evt.event_code  = eventCode_q;
    assign evt.pending     = pending_q;
    assign evt.overrun     = overrun_q;

    // All state registers. Reset parks the synchronizers at "released" and
    // last_grant at the top channel so channel 0 wins the first search.
    always_ff @(posedge clock) begin
        if (reset) begin
            syncA_q <= '1;
            syncB_q <= '1;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                chState_q[i] <= CH_IDLE;
                cnt_q[i]     <= '0;
            end
            arbState_q   <= ARB_IDLE;
            eventValid_q <= 1'b0;
            eventCode_q  <= '0;
            lastGrant_q  <= CODE_W'(NUM_BUTTONS - 1);
            pending_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            syncA_q <= buttonNotPressed;
            syncB_q <= syncA_q;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                chState_q[i] <= chState_d[i];
                cnt_q[i]     <= cnt_d[i];
            end
            arbState_q   <= arbState_d;
            eventValid_q <= eventValid_d;
            eventCode_q  <= eventCode_d;
            lastGrant_q  <= lastGrant_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
        end
    end

    // Per-channel debounce FSMs. A press is posted on the edge that accepts
    // the pressed level; holding or releasing posts nothing.
    always_comb begin
        post = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            chState_d[i] = chState_q[i];
            cnt_d[i]     = cnt_q[i];
            case (chState_q[i])
                CH_IDLE: begin
                    if (!syncB_q[i]) begin
                        chState_d[i] = CH_PRESS_WAIT;
                        cnt_d[i]     = '0;
                    end
                end
                CH_PRESS_WAIT: begin
                    if (syncB_q[i]) begin
                        chState_d[i] = CH_IDLE;
                        cnt_d[i]     = '0;
                    end else if (cnt_q[i] >= DONE_CNT) begin
                        chState_d[i] = CH_HELD;
                        cnt_d[i]     = '0;
                        post[i]      = 1'b1;
                    end else if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                CH_HELD: begin
                    if (syncB_q[i]) begin
                        chState_d[i] = CH_RELEASE_WAIT;
                        cnt_d[i]     = '0;
                    end
                end
                CH_RELEASE_WAIT: begin
                    if (!syncB_q[i]) begin
                        chState_d[i] = CH_HELD;
                        cnt_d[i]     = '0;
                    end else if (cnt_q[i] >= DONE_CNT) begin
                        chState_d[i] = CH_IDLE;
                        cnt_d[i]     = '0;
                    end else if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    chState_d[i] = CH_IDLE;
                    cnt_d[i]     = '0;
                end
            endcase
        end
    end

    // Round-robin arbiter and pending bookkeeping. The search only runs from
    // ARB_IDLE, which forces one idle cycle between consecutive offers. A post
    // landing on the edge its channel is acknowledged overrides the clear and
    // is not an overrun, because the old event was consumed.
    always_comb begin
        arbState_d   = arbState_q;
        eventValid_d = eventValid_q;
        eventCode_d  = eventCode_q;
        lastGrant_d  = lastGrant_q;
        clearMask    = '0;
        found        = 1'b0;
        pickIdx      = '0;

        for (int j = 1; j <= NUM_BUTTONS; j++) begin
            for (int k = 0; k < NUM_BUTTONS; k++) begin
                if (!found && pending_q[k] &&
                    (k == (int'(lastGrant_q) + j) % NUM_BUTTONS)) begin
                    found   = 1'b1;
                    pickIdx = CODE_W'(k);
                end
            end
        end

        case (arbState_q)
            ARB_IDLE: begin
                if (found) begin
                    arbState_d   = ARB_OFFER;
                    eventValid_d = 1'b1;
                    eventCode_d  = pickIdx;
                    lastGrant_d  = pickIdx;
                end
            end
            ARB_OFFER: begin
                if (evt.event_ack) begin
                    arbState_d   = ARB_IDLE;
                    eventValid_d = 1'b0;
                    for (int k = 0; k < NUM_BUTTONS; k++) begin
                        if (CODE_W'(k) == eventCode_q) begin
                            clearMask[k] = 1'b1;
                        end
                    end
                end
            end
            default: begin
                arbState_d   = ARB_IDLE;
                eventValid_d = 1'b0;
            end
        endcase

        pending_d = (pending_q & ~clearMask) | post;
        overrun_d = |(post & pending_q & ~clearMask);
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_button_event_arbiter
// Drives directed and random button/ack patterns into button_event_arbiter
// and compares every cycle against a behavioural model: each channel keeps
// an accepted level and a run length of disagreeing synchronized samples,
// and the arbiter is a pending bitmask served round-robin.
// ---------------------------------------------------------------------------
module tb_button_event_arbiter;

    localparam int NB   = 4;
    localparam int CW   = 2;
    localparam int DB   = 4;
    localparam int CNTW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] rawButtons = '1;
    logic          ackReg = 1'b0;
    logic          autoAck = 1'b0;
    logic          checkEnable = 1'b0;

    int totalChecks = 0;
    int badChecks   = 0;

    button_event_arbiter_if #(.NUM_BUTTONS(NB), .CODE_W(CW)) evt ();
    assign evt.event_ack = ackReg;

    button_event_arbiter #(
        .NUM_BUTTONS(NB),
        .CODE_W(CW),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(CNTW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .buttonNotPressed(rawButtons),
        .evt(evt.master)
    );

    always #5 clock = ~clock;

    // Inputs as seen by the DUT at each rising edge.
    logic [NB-1:0] rawS = '1;
    logic          ackS = 1'b0;
    logic          rstS = 1'b1;

    always @(posedge clock) begin
        rawS <= rawButtons;
        ackS <= ackReg;
        rstS <= reset;
    end

    // Reference model state.
    logic [NB-1:0] mSync1, mSync2, mAccepted, mPending;
    int            mRun [NB];
    logic          mOffering, mOverrun;
    int            mCode, mLast;

    // DUT-side monitors.
    int   grantLog[$];
    int   overrunCount = 0;
    logic prevValid = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Advance the model by the rising edge that just happened.
    task automatic updateModel();
        logic [NB-1:0] posts;
        logic [NB-1:0] clr;
        logic          got;
        posts = '0;
        clr   = '0;
        if (rstS) begin
            mSync1    = '1;
            mSync2    = '1;
            mAccepted = '1;
            for (int i = 0; i < NB; i++) mRun[i] = 0;
            mPending  = '0;
            mOffering = 1'b0;
            mOverrun  = 1'b0;
            mCode     = 0;
            mLast     = NB - 1;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (mSync2[i] != mAccepted[i]) begin
                    mRun[i]++;
                    if (mRun[i] == DB) begin
                        mAccepted[i] = ~mAccepted[i];
                        mRun[i] = 0;
                        if (!mAccepted[i]) posts[i] = 1'b1;
                    end
                end else begin
                    mRun[i] = 0;
                end
            end
            mSync2 = mSync1;
            mSync1 = rawS;
            if (mOffering) begin
                if (ackS) begin
                    clr[mCode] = 1'b1;
                    mOffering  = 1'b0;
                end
            end else if (mPending != 0) begin
                got = 1'b0;
                for (int j = 1; j <= NB; j++) begin
                    if (!got && mPending[(mLast + j) % NB]) begin
                        got       = 1'b1;
                        mCode     = (mLast + j) % NB;
                        mLast     = mCode;
                        mOffering = 1'b1;
                    end
                end
            end
            mOverrun = |(posts & mPending & ~clr);
            mPending = (mPending & ~clr) | posts;
        end
    endtask

    // Per-cycle comparison against the model plus DUT-side event logging.
    always @(negedge clock) begin
        updateModel();
        if (checkEnable) begin
            checkOutput("valid",   32'(evt.event_valid), 32'(mOffering));
            checkOutput("code",    32'(evt.event_code),  32'(mCode));
            checkOutput("pending", 32'(evt.pending),     32'(mPending));
            checkOutput("overrun", 32'(evt.overrun),     32'(mOverrun));
        end
        if (evt.event_valid && !prevValid) grantLog.push_back(int'(evt.event_code));
        if (evt.overrun) overrunCount++;
        prevValid = evt.event_valid;
    end

    task automatic applyStimulus(input logic [NB-1:0] raw, input int cycles);
        rawButtons = raw;
        repeat (cycles) begin
            @(negedge clock);
            if (autoAck) ackReg = evt.event_valid;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Valid"},   32'(evt.event_valid), 32'd0);
        checkOutput({tag, "Code"},    32'(evt.event_code),  32'd0);
        checkOutput({tag, "Pending"}, 32'(evt.pending),     32'd0);
        checkOutput({tag, "Overrun"}, 32'(evt.overrun),     32'd0);
    endtask

    initial begin
        int n;
        int ov;
        logic [NB-1:0] rnd;

        $display("[TB] start");
        repeat (3) @(negedge clock);
        checkEnable = 1'b1;
        checkAllZero("rst");
        reset = 1'b0;

        // Clean press on channel 2.
        applyStimulus(4'b1011, 5);
        checkOutput("cleanPendEarly", 32'(evt.pending), 32'h0);
        applyStimulus(4'b1011, 1);
        checkOutput("cleanPend", 32'(evt.pending), 32'h4);
        checkOutput("cleanValidLate", 32'(evt.event_valid), 32'd0);
        applyStimulus(4'b1011, 1);
        checkOutput("cleanValid", 32'(evt.event_valid), 32'd1);
        checkOutput("cleanCode", 32'(evt.event_code), 32'd2);
        ackReg = 1'b1;
        applyStimulus(4'b1011, 1);
        ackReg = 1'b0;
        checkOutput("cleanAckPend", 32'(evt.pending), 32'h0);
        checkOutput("cleanAckValid", 32'(evt.event_valid), 32'd0);
        applyStimulus(4'b1111, 10);

        // Bounce on channel 1: low runs of three samples never qualify.
        n = grantLog.size();
        for (int r = 0; r < 5; r++) begin
            applyStimulus(4'b1101, 3);
            applyStimulus(4'b1111, 1);
        end
        checkOutput("bouncePend", 32'(evt.pending), 32'h0);
        checkOutput("bounceNoEvt", 32'(grantLog.size()), 32'(n));
        autoAck = 1'b1;
        applyStimulus(4'b1101, 12);
        applyStimulus(4'b1111, 12);
        checkOutput("bounceOneEvt", 32'(grantLog.size()), 32'(n + 1));
        checkOutput("bounceCode", 32'(grantLog[grantLog.size() - 1]), 32'd1);

        // Round robin from a fresh reset so channel 0 is searched first.
        ackReg = 1'b0;
        reset = 1'b1;
        applyStimulus(4'b1111, 2);
        reset = 1'b0;
        n = grantLog.size();
        applyStimulus(4'b0100, 20);
        applyStimulus(4'b1111, 12);
        applyStimulus(4'b0110, 20);
        applyStimulus(4'b1111, 12);
        checkOutput("rrCount", 32'(grantLog.size()), 32'(n + 5));
        if (grantLog.size() >= n + 5) begin
            checkOutput("rrFirst",  32'(grantLog[n]),     32'd0);
            checkOutput("rrSecond", 32'(grantLog[n + 1]), 32'd1);
            checkOutput("rrThird",  32'(grantLog[n + 2]), 32'd3);
            checkOutput("rrAgainA", 32'(grantLog[n + 3]), 32'd0);
            checkOutput("rrAgainB", 32'(grantLog[n + 4]), 32'd3);
        end

        // Overrun: re-press channel 0 while its event is unacknowledged.
        autoAck = 1'b0;
        ackReg = 1'b0;
        ov = overrunCount;
        applyStimulus(4'b1110, 10);
        applyStimulus(4'b1111, 10);
        applyStimulus(4'b1110, 10);
        checkOutput("ovrPulses", 32'(overrunCount), 32'(ov + 1));
        checkOutput("ovrPend", 32'(evt.pending), 32'h1);
        ackReg = 1'b1;
        applyStimulus(4'b1110, 1);
        ackReg = 1'b0;
        checkOutput("ovrAckPend", 32'(evt.pending), 32'h0);
        checkOutput("ovrAckValid", 32'(evt.event_valid), 32'd0);
        applyStimulus(4'b1111, 10);

        // Ack on the same edge as a new post for the offered channel 3.
        applyStimulus(4'b0111, 10);
        checkOutput("colOffer", 32'(evt.event_code), 32'd3);
        applyStimulus(4'b1111, 10);
        ov = overrunCount;
        applyStimulus(4'b0111, 5);
        ackReg = 1'b1;
        applyStimulus(4'b0111, 1);
        ackReg = 1'b0;
        checkOutput("colPend", 32'(evt.pending), 32'h8);
        checkOutput("colIdle", 32'(evt.event_valid), 32'd0);
        applyStimulus(4'b0111, 1);
        checkOutput("colReValid", 32'(evt.event_valid), 32'd1);
        checkOutput("colReCode", 32'(evt.event_code), 32'd3);
        applyStimulus(4'b0111, 1);
        checkOutput("colNoOvr", 32'(overrunCount), 32'(ov));
        autoAck = 1'b1;
        applyStimulus(4'b1111, 12);

        // Reset during a press, then during an offer.
        autoAck = 1'b0;
        ackReg = 1'b0;
        applyStimulus(4'b1101, 3);
        reset = 1'b1;
        applyStimulus(4'b1101, 1);
        checkAllZero("rstPress");
        reset = 1'b0;
        applyStimulus(4'b1101, 5);
        checkOutput("rstHeldEarly", 32'(evt.pending), 32'h0);
        applyStimulus(4'b1101, 1);
        checkOutput("rstHeldPend", 32'(evt.pending), 32'h2);
        applyStimulus(4'b1101, 1);
        checkOutput("rstHeldValid", 32'(evt.event_valid), 32'd1);
        reset = 1'b1;
        applyStimulus(4'b1101, 1);
        checkAllZero("rstOffer");
        reset = 1'b0;
        autoAck = 1'b1;
        applyStimulus(4'b1111, 12);

        // Random buttons with slowly changing levels and random acks.
        autoAck = 1'b0;
        rnd = '1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) rnd[$urandom_range(0, NB - 1)] ^= 1'b1;
            ackReg = 1'($urandom_range(0, 1));
            applyStimulus(rnd, 1);
        end
        ackReg = 1'b0;
        autoAck = 1'b1;
        applyStimulus(4'b1111, 40);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Front-panel input controller for the ATM coin machine. It synchronizes and debounces NUM_BUTTONS raw active-low buttons (coin slots and keypad) and turns each clean press into one pending event. A round-robin arbiter shares the single processor event port among those requesters: it presents one event code at a time and holds it until the processor acknowledges.

## Interface
- NUM_BUTTONS, default 4: number of button channels, 2..8.
- CODE_W, default 2: event_code width; NUM_BUTTONS ≤ 2**CODE_W.
- DEBOUNCE_CYCLES, default 50000: consecutive stable samples required to accept a level change, ≥ 2.
- CNT_W, default 16: debounce counter width; DEBOUNCE_CYCLES < 2**CNT_W.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clock.
- buttonNotPressed  in  NUM_BUTTONS  raw asynchronous buttons, 0 = pressed.
- event_ack  in  1  processor has consumed the event_code on offer; ignored while event_valid = 0.
- event_valid  out  1  an event is on offer.
- event_code  out  CODE_W  channel index of the offered event; stable while event_valid = 1.
- pending  out  NUM_BUTTONS  per-channel posted-but-unacknowledged flags.
- overrun  out  1  one-cycle pulse when a press is merged into an already-pending event.

## Operation
Per-channel path:
- Two-flop synchronizer on each buttonNotPressed bit. Reset value 1 (released).
- Four-state channel FSM:
  - IDLE: sync = 0 → PRESS_WAIT, counter cleared.
  - PRESS_WAIT: sync = 0 increments the counter. When the counter reaches DEBOUNCE_CYCLES-1 → HELD and post the event. sync = 1 → IDLE, counter cleared.
  - HELD: sync = 1 → RELEASE_WAIT, counter cleared. Holding the button posts nothing further.
  - RELEASE_WAIT: same counting rule with sync = 1. Done → IDLE. sync = 0 → HELD, counter cleared.
- Posting an event sets pending[i].
  - If pending[i] is already 1, it stays 1 and overrun pulses for one cycle.
- The counter saturates and never wraps.

Arbiter (IDLE_ARB / OFFER):
- IDLE_ARB: if pending ≠ 0, pick the first set bit searching upward from last_grant+1 mod NUM_BUTTONS. Register its index into event_code, set event_valid = 1 and last_grant = index, then go to OFFER.
- OFFER: event_code and event_valid hold until event_ack = 1 is sampled. On that edge:
  - pending[event_code] clears.
  - event_valid drops.
  - The arbiter returns to IDLE_ARB.
- Simultaneous ack and new post on the granted channel: the post wins. pending stays 1 and overrun does not pulse.
- Posts on other channels during OFFER only set pending bits. They are never reordered ahead of the current offer.
- Reset values:
  - event_valid = 0, event_code = 0, pending = 0, overrun = 0.
  - last_grant = NUM_BUTTONS-1, so channel 0 wins first.
  - All channel FSMs IDLE, counters 0.
- Reset mid-press discards the press. A button still held after reset is re-debounced as a new press.

## Timing
- Raw input low before edge k and held: synchronizer output is low after edge k+1. pending[i] rises after edge k+1+DEBOUNCE_CYCLES.
- pending → event_valid: one edge, if the arbiter is in IDLE_ARB.
- event_ack sampled at edge m: event_valid = 0 after m. The earliest next event_valid = 1 is after m+1, so there is at least one idle cycle between offers.
- event_ack held high continuously consumes at most one event per two cycles.
- overrun is asserted for exactly the cycle following the merging post.
- Bounce shorter than DEBOUNCE_CYCLES stable samples produces no event and no pending change.

## Test plan
- DEBOUNCE_CYCLES=4, NUM_BUTTONS=4:
  - Stimulus: channel 2 pressed clean.
  - Required: pending=0100 six edges after the first low sample, then event_valid=1 with event_code=2 one edge later. Ack → pending=0000, event_valid=0.
- Bounce:
  - Stimulus: channel 1 toggles low 3 cycles / high 1 cycle repeatedly, then holds low.
  - Required: no event during the toggling, exactly one event after the hold, none on release.
- Round robin:
  - Stimulus: channels 0, 1 and 3 post on the same edge; ack each offer immediately.
  - Required: codes in order 0, 1, 3, with one idle cycle between offers. Channels 0 and 3 again pending → 0 is served before 3.
- Overrun:
  - Stimulus: press, release and re-press channel 0 while its event is unacked.
  - Required: one overrun pulse, pending[0] stays 1, and a single ack clears it.
- Ack/post collision:
  - Stimulus: ack arrives on the same edge as a new post for the offered channel.
  - Required: pending stays 1, no overrun, re-offered after the idle cycle.
- Reset:
  - Stimulus: reset during PRESS_WAIT and again during OFFER.
  - Required: all outputs 0 the next edge. A held button yields a fresh event DEBOUNCE_CYCLES+2 edges after reset falls.
